// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the AHB-to-APB bridge controller.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS,
    ERRA,
    ERR2
  } state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    while ((64'(1) << res) < 64'(val)) res++;
    return res;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS wait counter; expired_c flags that MAX wait cycles were seen.
module apb_timeout_ctr
  import apb_bridge_pkg::*;
#(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  generate
    if (MAX == 0) begin : g_off
      // Timeout disabled: inputs intentionally ignored.
      logic unused_in;
      assign unused_in = ^{clk, rst, clr, en};
      assign expired_c = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = clog2(MAX + 1);
      logic [CW-1:0] cnt;

      // Count pready-low cycles, holding at MAX instead of wrapping.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && (cnt != CW'(MAX))) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expired_c = (cnt == CW'(MAX));
    end
  endgenerate

endmodule

// File: rtl/ahb2apb_bridge_ctrl.sv
// AHB-slave to APB-master bridge: one-hot slave select, PREADY waits,
// PSLVERR/timeout mapped to a two-cycle AHB ERROR response.
module ahb2apb_bridge_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NSLV        = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hvalid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [NSLV-1:0]   hsel_slv,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [NSLV-1:0]   sel_q;

  logic accept_c;
  logic tmo_clr_c;
  logic tmo_en_c;
  logic tmo_expired_c;

  // hreadyout is high only in IDLE and ERR2, so this is the accept condition.
  assign accept_c  = hvalid && hreadyout;
  // Counter clears on every transition into SETUP.
  assign tmo_clr_c = (state == WWAIT) || (accept_c && (hsel_slv != '0) && !hwrite);
  assign tmo_en_c  = (state == ACCESS) && !pready;

  apb_timeout_ctr #(
    .MAX(TIMEOUT_CYC)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr_c),
    .en       (tmo_en_c),
    .expired_c(tmo_expired_c)
  );

  // Bridge FSM; every output is loaded with the value of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hrdata    <= '0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      addr_q    <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          state     <= IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
          if (accept_c) begin
            addr_q    <= haddr;
            write_q   <= hwrite;
            sel_q     <= hsel_slv;
            hreadyout <= 1'b0;
            if (hsel_slv == '0) begin
              state <= ERRA;
              hresp <= HRESP_ERROR;
            end else if (hwrite) begin
              state <= WWAIT;
            end else begin
              state  <= SETUP;
              psel   <= hsel_slv;
              paddr  <= haddr;
              pwrite <= 1'b0;
            end
          end
        end
        WWAIT: begin
          state  <= SETUP;
          pwdata <= hwdata;
          psel   <= sel_q;
          paddr  <= addr_q;
          pwrite <= 1'b1;
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            psel    <= '0;
            penable <= 1'b0;
            if (pslverr) begin
              state <= ERRA;
              hresp <= HRESP_ERROR;
            end else begin
              state     <= IDLE;
              hreadyout <= 1'b1;
              if (!write_q) hrdata <= prdata;
            end
          end else if (tmo_expired_c) begin
            psel    <= '0;
            penable <= 1'b0;
            state   <= ERRA;
            hresp   <= HRESP_ERROR;
          end
        end
        ERRA: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          psel      <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Multi-hot slave selects are forwarded unchanged but flagged here.
  a_sel_onehot: assert property (@(posedge clk) disable iff (!rst)
    accept_c |-> $onehot0(hsel_slv));

endmodule

// File: tb/tb_ahb2apb_bridge_ctrl.sv
// Directed bench with a per-cycle timeline model of the AHB-to-APB bridge.
module tb_ahb2apb_bridge_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        hvalid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsel_slv;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  ahb2apb_bridge_ctrl #(
    .ADDR_W(32), .DATA_W(32), .NSLV(3), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .hvalid(hvalid), .hwrite(hwrite), .haddr(haddr),
    .hsel_slv(hsel_slv), .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        hreadyout;
    logic        hresp;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
  } out_t;

  out_t expv [int];
  out_t last;
  out_t mdl_hold;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, ex);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    expv.delete();
    mdl_hold = '0;
    last = '0;
    last.hreadyout = 1'b1;
  endtask

  // Expected output timeline of one transfer accepted in the current cycle.
  task automatic plan(input logic wr, input logic [31:0] addr, input logic [2:0] sel,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int waits, input logic err);
    out_t r;
    int   t;
    int   n_acc;
    logic tmo_hit;
    t = cyc + 1;
    r = mdl_hold;
    r.hreadyout = 1'b0;
    r.hresp = 1'b0;
    r.psel = 3'b000;
    r.penable = 1'b0;
    if (sel == 3'b000) begin
      r.hresp = 1'b1;
      expv[t] = r;
      r.hreadyout = 1'b1;
      expv[t+1] = r;
      return;
    end
    if (wr) begin
      expv[t] = r;
      t++;
      r.pwdata = wdata;
    end
    r.psel = sel;
    r.paddr = addr;
    r.pwrite = wr;
    expv[t] = r;
    t++;
    r.penable = 1'b1;
    tmo_hit = (TMO != 0) && (waits > TMO);
    n_acc = tmo_hit ? TMO + 1 : waits + 1;
    repeat (n_acc) begin
      expv[t] = r;
      t++;
    end
    r.psel = 3'b000;
    r.penable = 1'b0;
    if (tmo_hit || err) begin
      r.hresp = 1'b1;
      expv[t] = r;
      t++;
      r.hreadyout = 1'b1;
      expv[t] = r;
    end else begin
      r.hreadyout = 1'b1;
      if (!wr) r.hrdata = rdata;
      expv[t] = r;
    end
    mdl_hold = r;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    out_t e;
    if (rst && chk_on) begin
      if (expv.exists(cyc)) begin
        e = expv[cyc];
      end else begin
        e = last;
        e.hreadyout = 1'b1;
        e.hresp = 1'b0;
        e.psel = 3'b000;
        e.penable = 1'b0;
      end
      chk("hreadyout", 32'(hreadyout), 32'(e.hreadyout));
      chk("hresp", 32'(hresp), 32'(e.hresp));
      chk("psel", 32'(psel), 32'(e.psel));
      chk("penable", 32'(penable), 32'(e.penable));
      chk("pwrite", 32'(pwrite), 32'(e.pwrite));
      chk("paddr", paddr, e.paddr);
      chk("pwdata", pwdata, e.pwdata);
      chk("hrdata", hrdata, e.hrdata);
      last = e;
    end
  end

  // Drive one transfer from its accept cycle; returns in the next cycle that can accept.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] sel,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input logic err, output int lat);
    int c;
    int acc_start;
    int n_acc;
    logic tmo_hit;
    c = cyc;
    plan(wr, addr, sel, wdata, rdata, waits, err);
    hvalid = 1'b1;
    hwrite = wr;
    haddr = addr;
    hsel_slv = sel;
    pready = 1'b0;
    pslverr = 1'b0;
    step();
    hvalid = 1'b0;
    hwdata = wr ? wdata : 32'hBAD0_BAD0;
    if (sel == 3'b000) begin
      step();
      lat = cyc - c;
      return;
    end
    step();
    hwdata = 32'hBAD0_BAD0;
    acc_start = c + (wr ? 3 : 2);
    while (cyc < acc_start) step();
    tmo_hit = (TMO != 0) && (waits > TMO);
    n_acc = tmo_hit ? TMO + 1 : waits + 1;
    for (int k = 0; k < n_acc; k++) begin
      pready = (k == waits);
      pslverr = (k == waits) && err;
      prdata = rdata;
      step();
    end
    pready = 1'b0;
    pslverr = 1'b0;
    if (tmo_hit || err) step();
    lat = cyc - c;
  endtask

  initial begin
    int lat;
    int lat2;
    rst = 1'b0;
    hvalid = 1'b0;
    hwrite = 1'b0;
    haddr = '0;
    hsel_slv = '0;
    hwdata = '0;
    prdata = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    model_reset();
    repeat (2) step();
    chk("rst_hreadyout", 32'(hreadyout), 1);
    chk("rst_hresp", 32'(hresp), 0);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_hrdata", hrdata, 0);
    rst = 1'b1;
    chk_on = 1'b1;
    step();

    // Zero-wait read from slave 1.
    run_txn(1'b0, 32'h40, 3'b010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, lat);
    chk("rd_lat", 32'(lat), 3);
    chk("rd_hrdata", hrdata, 32'hDEAD_BEEF);
    chk("rd_ready", 32'(hreadyout), 1);
    hvalid = 1'b0;
    repeat (2) step();

    // Read ending in PSLVERR after one wait.
    run_txn(1'b0, 32'h80, 3'b100, 32'h0, 32'hCAFE_F00D, 1, 1'b1, lat);
    chk("slverr_lat", 32'(lat), 5);
    chk("slverr_hresp", 32'(hresp), 1);
    chk("slverr_hrdata_kept", hrdata, 32'hDEAD_BEEF);
    hvalid = 1'b0;
    step();

    // Write with three wait states.
    run_txn(1'b1, 32'h10, 3'b001, 32'h1234_5678, 32'h0, 3, 1'b0, lat);
    chk("wr_lat", 32'(lat), 7);
    chk("wr_pwdata", pwdata, 32'h1234_5678);
    chk("wr_paddr", paddr, 32'h10);
    chk("wr_pwrite", 32'(pwrite), 1);

    // Back-to-back read that never sees pready: timeout.
    run_txn(1'b0, 32'h44, 3'b010, 32'h0, 32'h0, 100, 1'b0, lat);
    chk("tmo_lat", 32'(lat), 8);
    chk("tmo_hresp", 32'(hresp), 1);

    // Unmapped write, then write and read back-to-back starting from ERR2.
    run_txn(1'b1, 32'h999, 3'b000, 32'h5555_5555, 32'h0, 0, 1'b0, lat);
    chk("unmapped_lat", 32'(lat), 2);
    chk("unmapped_pwdata_kept", pwdata, 32'h1234_5678);
    run_txn(1'b1, 32'h20, 3'b100, 32'hA5A5_A5A5, 32'h0, 0, 1'b0, lat);
    run_txn(1'b0, 32'h24, 3'b001, 32'h0, 32'h0BAD_F00D, 0, 1'b0, lat2);
    chk("b2b_wr_lat", 32'(lat), 4);
    chk("b2b_rd_lat", 32'(lat2), 3);
    chk("b2b_hrdata", hrdata, 32'h0BAD_F00D);
    hvalid = 1'b0;
    repeat (2) step();

    // Asynchronous reset during ACCESS.
    plan(1'b0, 32'h50, 3'b001, 32'h0, 32'h55, 100, 1'b0);
    hvalid = 1'b1;
    hwrite = 1'b0;
    haddr = 32'h50;
    hsel_slv = 3'b001;
    step();
    hvalid = 1'b0;
    step();
    chk("mid_penable", 32'(penable), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_psel", 32'(psel), 0);
    chk("arst_penable", 32'(penable), 0);
    chk("arst_hreadyout", 32'(hreadyout), 1);
    chk("arst_hresp", 32'(hresp), 0);
    chk("arst_paddr", paddr, 0);
    chk("arst_pwdata", pwdata, 0);
    chk("arst_hrdata", hrdata, 0);
    chk("arst_pwrite", 32'(pwrite), 0);
    model_reset();
    #3 rst = 1'b1;
    step();

    // Normal read after reset.
    run_txn(1'b0, 32'h48, 3'b010, 32'h0, 32'h1122_3344, 0, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 3);
    chk("post_rst_hrdata", hrdata, 32'h1122_3344);
    hvalid = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
